dense_layer_sched: RTL and testbench
====================================

# dense_layer_sched

Controller that sequences one 24×24 feature-map frame through the shared dense-layer multiply-accumulate datapath. It accepts pixels over a valid/ready stream and issues the matching weight-ROM address for each one. It delays each pixel so that it meets its weight at the MAC, and brackets the frame with accumulator clear and result handshake. It sits between the convolution/pooling stage and the dense MAC/weight ROM that produce the hcount/vcount position predictions.

## Interface
Parameters:
- ROWS, 24, feature-map rows per frame
- COLS, 24, feature-map columns per frame
- ROM_LATENCY, 2, weight-ROM read latency in cycles (HIGH_PERFORMANCE mode)
- ADDR_W, 10, ROM address width; must satisfy 2^ADDR_W ≥ ROWS*COLS

Ports:
- clk_in  input  1  single clock
- rst_n_in  input  1  asynchronous, active-low reset
- start_in  input  1  one-cycle frame start; ignored unless IDLE
- pixel_valid_in  input  1  pixel stream valid
- pixel_ready_out  output  1  pixel stream ready
- pixel_data_in  input  21  feature pixel
- hcount_in  input  5  column tag of pixel
- vcount_in  input  5  row tag of pixel
- rom_en_out  output  1  weight-ROM read enable
- rom_addr_out  output  ADDR_W  weight-ROM address = row*COLS+col
- mac_clr_out  output  1  clear both accumulators
- mac_en_out  output  1  accumulate this cycle
- mac_pixel_out  output  21  pixel aligned with ROM data
- result_valid_out  output  1  accumulators hold final frame result
- result_ready_in  input  1  consumer takes result
- busy_out  output  1  high in any state but IDLE
- order_err_out  output  1  sticky pixel-order error

## Operation
- States: IDLE, CLEAR, RUN, DRAIN, EMIT.
- IDLE: pixel_ready_out=0. If start_in=1, go to CLEAR and clear order_err_out.
- CLEAR: one cycle with mac_clr_out=1. Zero the row/col/index counters. Go to RUN.
- RUN: pixel_ready_out=1. On accept (valid&&ready):
  - register rom_en_out=1 and rom_addr_out=index;
  - push the pixel into a ROM_LATENCY+1-deep alignment shift register with a valid bit;
  - advance col; wrap col at COLS-1 to 0 and increment row.
  - On accepting index ROWS*COLS-1, pixel_ready_out drops the next cycle and the state goes to DRAIN.
  - Bubbles (valid low) insert no MAC enables.
- DRAIN: hold for exactly ROM_LATENCY+2 cycles so the last mac_en_out retires and the MAC output registers. Then go to EMIT.
- EMIT: result_valid_out=1 until result_ready_in=1. Go to IDLE on the cycle after the handshake.
- Alignment shift register output drives mac_en_out and mac_pixel_out. mac_pixel_out holds its last value when mac_en_out=0.
- start_in while busy: ignored, no effect.
- Reset mid-frame: all state, counters and the pipeline clear asynchronously. No stale mac_en_out appears after release.

## Timing
- Reset values: every output is 0, and the state is IDLE.
- Accept in cycle t:
  - rom_en_out and rom_addr_out are valid in cycle t+1.
  - mac_en_out and mac_pixel_out are valid in cycle t+1+ROM_LATENCY (t+3 at default).
- Frame latency with no bubbles: start_in at cycle s gives CLEAR at s+1 and the first accept at s+2. The last accept is at s+2+575. result_valid_out rises at s+2+575+1+ROM_LATENCY+2 = s+582.
- rom_en_out is high only in cycles following an accept. Back-to-back accepts give back-to-back reads.
- mac_clr_out never overlaps mac_en_out.

## Configuration
- DENSE_SCHED_ORDER_CHECK_EN:
  - Defined: on each accept, compare hcount_in/vcount_in with the internal col/row. A mismatch sets order_err_out (sticky until the next start_in) and the frame proceeds with internal counts.
  - Undefined: hcount_in/vcount_in are unused and order_err_out is tied 0.

## Test plan
- Reset with rst_n_in=0 mid-RUN at index 100 → all outputs 0 immediately. After release the state is IDLE and no mac_en_out pulses occur.
- start_in, then 576 back-to-back pixels with data=index:
  - rom_addr_out runs 0..575 contiguously;
  - mac_pixel_out equals the address issued ROM_LATENCY cycles earlier;
  - result_valid_out rises at s+582.
- Random pixel_valid_in bubbles (30%) → exactly 576 mac_en_out pulses, and address/pixel alignment is preserved.
- result_ready_in held low 10 cycles in EMIT → result_valid_out stays 1, pixel_ready_out=0, busy_out=1. The state returns to IDLE after the handshake.
- start_in pulsed during RUN at index 200 → ignored, and the counters continue to 575.
- With DENSE_SCHED_ORDER_CHECK_EN, pixel 30 tagged hcount=7, vcount=1 (expected 6,1) → order_err_out=1 stays set until the next start_in. Without the macro it stays 0.

Source files
------------

// File: rtl/dense_layer_sched.sv
// dense_layer_sched: walks one ROWSxCOLS frame through the shared dense MAC / weight-ROM datapath.
// Optional macro DENSE_SCHED_ORDER_CHECK_EN enables the hcount/vcount pixel-order check.
module dense_layer_sched #(
  parameter int ROWS        = 24,
  parameter int COLS        = 24,
  parameter int ROM_LATENCY = 2,
  parameter int ADDR_W      = 10
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              start_in,
  input  logic              pixel_valid_in,
  output logic              pixel_ready_out,
  input  logic [20:0]       pixel_data_in,
  input  logic [4:0]        hcount_in,
  input  logic [4:0]        vcount_in,
  output logic              rom_en_out,
  output logic [ADDR_W-1:0] rom_addr_out,
  output logic              mac_clr_out,
  output logic              mac_en_out,
  output logic [20:0]       mac_pixel_out,
  output logic              result_valid_out,
  input  logic              result_ready_in,
  output logic              busy_out,
  output logic              order_err_out
);

  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int DRN_W = $clog2(ROM_LATENCY + 3);
  localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(ROWS * COLS - 1);
  localparam logic [COL_W-1:0]  LAST_COL   = COL_W'(COLS - 1);
  localparam logic [DRN_W-1:0]  DRAIN_LAST = DRN_W'(ROM_LATENCY + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_EMIT
  } state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic [ADDR_W-1:0] r_index;
  logic [COL_W-1:0]  r_col;
  logic [ROW_W-1:0]  r_row;
  logic [DRN_W-1:0]  r_drainCnt;
  logic              r_romEn;
  logic [ADDR_W-1:0] r_romAddr;
  logic              r_pipeVld  [0:ROM_LATENCY];
  logic [20:0]       r_pipeData [0:ROM_LATENCY];
  logic              w_inVld    [0:ROM_LATENCY];
  logic [20:0]       w_inData   [0:ROM_LATENCY];
  logic              w_accept;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_state <= S_IDLE;
    else           r_state <= w_nextState;
  end

  always_comb begin
    w_nextState      = r_state;
    pixel_ready_out  = 1'b0;
    mac_clr_out      = 1'b0;
    result_valid_out = 1'b0;
    busy_out         = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy_out = 1'b0;
        if (start_in) w_nextState = S_CLEAR;
      end
      S_CLEAR: begin
        mac_clr_out = 1'b1;
        w_nextState = S_RUN;
      end
      S_RUN: begin
        pixel_ready_out = 1'b1;
        if (pixel_valid_in && (r_index == LAST_IDX)) w_nextState = S_DRAIN;
      end
      S_DRAIN: begin
        if (r_drainCnt == DRAIN_LAST) w_nextState = S_EMIT;
      end
      S_EMIT: begin
        result_valid_out = 1'b1;
        if (result_ready_in) w_nextState = S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  assign w_accept = pixel_valid_in && pixel_ready_out;

  // Raster position of the next pixel; the drain counter times the pipeline flush.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_index    <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_drainCnt <= '0;
    end else begin
      if (r_state == S_CLEAR) begin
        r_index <= '0;
        r_col   <= '0;
        r_row   <= '0;
      end else if (w_accept) begin
        r_index <= r_index + 1'b1;
        if (r_col == LAST_COL) begin
          r_col <= '0;
          r_row <= r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
      if (r_state == S_DRAIN) r_drainCnt <= r_drainCnt + 1'b1;
      else                    r_drainCnt <= '0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_romEn   <= 1'b0;
      r_romAddr <= '0;
    end else begin
      r_romEn <= w_accept;
      if (w_accept) r_romAddr <= r_index;
    end
  end

  // Stage k holds a pixel accepted k+1 cycles ago; data only moves with its valid bit,
  // so the last stage keeps presenting the previous pixel between enables.
  always_comb begin
    w_inVld[0]  = w_accept;
    w_inData[0] = pixel_data_in;
    for (int k = 1; k <= ROM_LATENCY; k++) begin
      w_inVld[k]  = r_pipeVld[k-1];
      w_inData[k] = r_pipeData[k-1];
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int k = 0; k <= ROM_LATENCY; k++) begin
        r_pipeVld[k]  <= 1'b0;
        r_pipeData[k] <= '0;
      end
    end else begin
      for (int k = 0; k <= ROM_LATENCY; k++) begin
        r_pipeVld[k] <= w_inVld[k];
        if (w_inVld[k]) r_pipeData[k] <= w_inData[k];
      end
    end
  end

  assign rom_en_out    = r_romEn;
  assign rom_addr_out  = r_romAddr;
  assign mac_en_out    = r_pipeVld[ROM_LATENCY];
  assign mac_pixel_out = r_pipeData[ROM_LATENCY];

`ifdef DENSE_SCHED_ORDER_CHECK_EN
  logic r_orderErr;

  // Sticky until the next accepted start; the frame keeps using internal counts.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_orderErr <= 1'b0;
    end else if ((r_state == S_IDLE) && start_in) begin
      r_orderErr <= 1'b0;
    end else if (w_accept && ((hcount_in != 5'(r_col)) || (vcount_in != 5'(r_row)))) begin
      r_orderErr <= 1'b1;
    end
  end

  assign order_err_out = r_orderErr;
`else
  logic w_unusedTags;
  assign w_unusedTags  = ^{hcount_in, vcount_in, r_row};
  assign order_err_out = 1'b0;
`endif

endmodule

// File: tb/tb_dense_layer_sched.sv
// Self-checking bench for dense_layer_sched against a cycle-arithmetic frame model.
// Honours DENSE_SCHED_ORDER_CHECK_EN when deciding whether order_err_out should ever rise.
module tb_dense_layer_sched;

  localparam int ROWS   = 24;
  localparam int COLS   = 24;
  localparam int LAT    = 2;
  localparam int ADDR_W = 10;
  localparam int NPIX   = ROWS * COLS;

`ifdef DENSE_SCHED_ORDER_CHECK_EN
  localparam bit ORDER_CHK = 1'b1;
`else
  localparam bit ORDER_CHK = 1'b0;
`endif

  logic              clk_in          = 1'b0;
  logic              rst_n_in        = 1'b1;
  logic              start_in        = 1'b0;
  logic              pixel_valid_in  = 1'b0;
  logic [20:0]       pixel_data_in   = '0;
  logic [4:0]        hcount_in       = '0;
  logic [4:0]        vcount_in       = '0;
  logic              result_ready_in = 1'b0;
  logic              pixel_ready_out;
  logic              rom_en_out;
  logic [ADDR_W-1:0] rom_addr_out;
  logic              mac_clr_out;
  logic              mac_en_out;
  logic [20:0]       mac_pixel_out;
  logic              result_valid_out;
  logic              busy_out;
  logic              order_err_out;

  dense_layer_sched #(
    .ROWS(ROWS), .COLS(COLS), .ROM_LATENCY(LAT), .ADDR_W(ADDR_W)
  ) dut (
    .clk_in(clk_in),
    .rst_n_in(rst_n_in),
    .start_in(start_in),
    .pixel_valid_in(pixel_valid_in),
    .pixel_ready_out(pixel_ready_out),
    .pixel_data_in(pixel_data_in),
    .hcount_in(hcount_in),
    .vcount_in(vcount_in),
    .rom_en_out(rom_en_out),
    .rom_addr_out(rom_addr_out),
    .mac_clr_out(mac_clr_out),
    .mac_en_out(mac_en_out),
    .mac_pixel_out(mac_pixel_out),
    .result_valid_out(result_valid_out),
    .result_ready_in(result_ready_in),
    .busy_out(busy_out),
    .order_err_out(order_err_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int cyc;
    int val;
  } ev_t;

  ev_t romQ[$];
  ev_t macQ[$];

  int nCmp = 0;
  int nFail = 0;
  int cyc = 0;
  bit frameOn = 1'b0;
  int sCyc = 0;
  int nAcc = 0;
  int lastAcc = -1;
  int hsCyc = -1;
  bit errExp = 1'b0;
  int lastMac = 0;
  int rvCycles = 0;
  int riseCyc = -1;
  int macPulses = 0;
  bit prevRv = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: compare this cycle's outputs with the frame model, then drive inputs.
  task automatic applyStimulus(input bit st, input bit vld, input int data,
                               input int hc, input int vc, input bit rr);
    bit  busyE, clrE, readyE, rvE, romE, macE;
    int  romA;
    ev_t e;
    @(negedge clk_in);
    if (frameOn && hsCyc >= 0 && cyc > hsCyc) frameOn = 1'b0;
    busyE  = frameOn && cyc > sCyc && (hsCyc < 0 || cyc <= hsCyc);
    clrE   = frameOn && cyc == sCyc + 1;
    readyE = frameOn && cyc >= sCyc + 2 && nAcc < NPIX;
    rvE    = frameOn && lastAcc >= 0 && cyc >= lastAcc + LAT + 3 && (hsCyc < 0 || cyc <= hsCyc);
    romE   = romQ.size() > 0 && romQ[0].cyc == cyc;
    romA   = 0;
    if (romE) begin
      e    = romQ.pop_front();
      romA = e.val;
    end
    macE = macQ.size() > 0 && macQ[0].cyc == cyc;
    if (macE) begin
      e       = macQ.pop_front();
      lastMac = e.val;
    end
    checkOutput("busy", 32'(busy_out), 32'(busyE));
    checkOutput("mac_clr", 32'(mac_clr_out), 32'(clrE));
    checkOutput("pixel_ready", 32'(pixel_ready_out), 32'(readyE));
    checkOutput("result_valid", 32'(result_valid_out), 32'(rvE));
    checkOutput("rom_en", 32'(rom_en_out), 32'(romE));
    if (romE) checkOutput("rom_addr", 32'(rom_addr_out), romA);
    checkOutput("mac_en", 32'(mac_en_out), 32'(macE));
    checkOutput("mac_pixel", 32'(mac_pixel_out), lastMac);
    checkOutput("order_err", 32'(order_err_out), 32'(errExp));
    if (result_valid_out && !prevRv) riseCyc = cyc;
    prevRv = result_valid_out;
    if (mac_en_out) macPulses++;
    if (rvE) rvCycles++;

    start_in        = st;
    pixel_valid_in  = vld;
    pixel_data_in   = 21'(data);
    hcount_in       = 5'(hc);
    vcount_in       = 5'(vc);
    result_ready_in = rr;

    if (st && !frameOn) begin
      frameOn   = 1'b1;
      sCyc      = cyc;
      nAcc      = 0;
      lastAcc   = -1;
      hsCyc     = -1;
      errExp    = 1'b0;
      rvCycles  = 0;
      riseCyc   = -1;
      macPulses = 0;
    end
    if (vld && readyE) begin
      e.cyc = cyc + 1;
      e.val = nAcc;
      romQ.push_back(e);
      e.cyc = cyc + 1 + LAT;
      e.val = data & 32'h1FFFFF;
      macQ.push_back(e);
      if (hc != nAcc % COLS || vc != nAcc / COLS) errExp = errExp | ORDER_CHK;
      nAcc++;
      if (nAcc == NPIX) lastAcc = cyc;
    end
    if (rvE && rr) hsCyc = cyc;
    cyc++;
  endtask

  task automatic doReset();
    #2 rst_n_in = 1'b0;
    #1;
    checkOutput("rst_pixel_ready", 32'(pixel_ready_out), 0);
    checkOutput("rst_rom_en", 32'(rom_en_out), 0);
    checkOutput("rst_rom_addr", 32'(rom_addr_out), 0);
    checkOutput("rst_mac_clr", 32'(mac_clr_out), 0);
    checkOutput("rst_mac_en", 32'(mac_en_out), 0);
    checkOutput("rst_mac_pixel", 32'(mac_pixel_out), 0);
    checkOutput("rst_result_valid", 32'(result_valid_out), 0);
    checkOutput("rst_busy", 32'(busy_out), 0);
    checkOutput("rst_order_err", 32'(order_err_out), 0);
    start_in        = 1'b0;
    pixel_valid_in  = 1'b0;
    result_ready_in = 1'b0;
    romQ.delete();
    macQ.delete();
    frameOn = 1'b0;
    errExp  = 1'b0;
    lastMac = 0;
    prevRv  = 1'b0;
    repeat (3) begin
      @(negedge clk_in);
      cyc++;
    end
    rst_n_in = 1'b1;
  endtask

  // Drives a whole frame; errIdx gets a wrong column tag, startIdx gets a stray start pulse,
  // abortIdx stops driving once that many pixels were taken (caller then resets).
  task automatic runFrame(input string name, input int bubblePct, input bit randData,
                          input int errIdx, input int startIdx, input int holdRdy,
                          input int abortIdx);
    int budget;
    bit v, st, rr;
    int d, hc, vc;
    applyStimulus(1'b1, 1'b0, 0, 0, 0, 1'b0);
    budget = 4000;
    while (frameOn && budget > 0) begin
      if (abortIdx >= 0 && nAcc >= abortIdx) break;
      v  = ($urandom_range(99, 0) >= bubblePct);
      d  = randData ? int'($urandom_range(32'h1FFFFF, 0)) : nAcc;
      hc = nAcc % COLS;
      vc = nAcc / COLS;
      if (nAcc == errIdx) hc = hc + 1;
      st = (nAcc == startIdx);
      rr = (rvCycles >= holdRdy);
      applyStimulus(st, v, d, hc, vc, rr);
      budget--;
    end
    if (abortIdx < 0) begin
      checkOutput({name, "_end_busy"}, 32'(busy_out), 0);
      checkOutput({name, "_mac_pulses"}, macPulses, NPIX);
      checkOutput({name, "_rv_rise"}, riseCyc, lastAcc + LAT + 3);
      if (bubblePct == 0)
        checkOutput({name, "_rv_rise_abs"}, riseCyc, sCyc + 2 + (NPIX - 1) + 1 + LAT + 2);
    end
  endtask

  initial begin
    $display("[TB] dense_layer_sched bench, order check expected=%0d", ORDER_CHK);
    doReset();
    repeat (3) applyStimulus(1'b0, 1'b0, 0, 0, 0, 1'b0);

    $display("[TB] frame A: back-to-back, data=index, bad tag at 30, stray start at 200, ready held 10");
    runFrame("frameA", 0, 1'b0, 30, 200, 10, -1);
    checkOutput("order_err_sticky", 32'(order_err_out), 32'(ORDER_CHK));

    $display("[TB] frame B: 30%% bubbles, random data");
    runFrame("frameB", 30, 1'b1, -1, -1, int'($urandom_range(4, 0)), -1);
    checkOutput("order_err_cleared", 32'(order_err_out), 0);

    $display("[TB] frame C: reset after 100 pixels");
    runFrame("frameC", 0, 1'b1, -1, -1, 0, 100);
    doReset();
    repeat (20) applyStimulus(1'b0, 1'b0, 0, 0, 0, 1'b0);

    $display("[TB] frame D: 30%% bubbles after reset");
    runFrame("frameD", 30, 1'b1, -1, -1, 2, -1);
    repeat (3) applyStimulus(1'b0, 1'b0, 0, 0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
